serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: computes diff = a - b - borrow_in one bit per clock, LSB first.

---
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor (diff = a - b - borrow_in), LSB first
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start              request, accepted while ready=1
//   a, b, borrow_in    operands, sampled on an accepted start
//   ready              1 in IDLE and DONE
//   busy               1 while shifting
//   done               one-cycle pulse; diff/borrow_out updated in the same cycle
//   diff, borrow_out   result registers, held until the next completion
//   overflow           signed overflow flag (only with OVERFLOW_FLAG_EN defined)
//
// Build option: OVERFLOW_FLAG_EN adds the overflow output.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 bits produced so far; the final bit joins them on the last edge.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             overflow_q, overflow_d;
`endif

  logic             load;
  logic             d_bit;
  logic [WIDTH-1:0] res_full;

  assign load = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    done_d       = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    overflow_d   = overflow_q;
`endif
    d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    res_full = {d_bit, res_sh_q};

    case (state_q)
      S_IDLE: ;
      S_SHIFT: begin
        br_d     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_full[WIDTH-1:1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Publish on the last shift edge so done and the new result appear together in DONE.
          state_d      = S_DONE;
          diff_d       = res_full;
          borrow_out_d = br_d;
          done_d       = 1'b1;
`ifdef OVERFLOW_FLAG_EN
          overflow_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_SHIFT;
      a_sh_d  = a;
      b_sh_d  = b;
      br_d    = borrow_in;
      cnt_d   = '0;
`ifdef OVERFLOW_FLAG_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_sh_q     <= res_sh_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      done_q       <= done_d;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy       = (state_q == S_SHIFT);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH 8 and 4)

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, bout8;
  logic [7:0] diff8;
`ifdef OVERFLOW_FLAG_EN
  logic       ovf8;
  logic       ovf4;
`endif

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, done4, bout4;
  logic [3:0] diff4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8),
`ifdef OVERFLOW_FLAG_EN
    .overflow(ovf8),
`endif
    .borrow_out(bout8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4),
`ifdef OVERFLOW_FLAG_EN
    .overflow(ovf4),
`endif
    .borrow_out(bout4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the current post-edge point until done8 is seen (bounded).
  task automatic wait_done8(output int cycles);
    cycles = 0;
    while (!done8 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] exp_diff, input logic exp_bout, input logic exp_ovf);
    int cyc;
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    tick();
    start8 = 1'b0;
    wait_done8(cyc);
    check_eq({tag, "_latency"}, cyc, 8);
    check_eq({tag, "_diff"}, diff8, exp_diff);
    check_eq({tag, "_bout"}, bout8, exp_bout);
`ifdef OVERFLOW_FLAG_EN
    check_eq({tag, "_ovf"}, ovf8, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected x flag");
`endif
    tick();
  endtask

  initial begin
    int cyc;
    int dones;
    int bad;
    int e;
    logic [3:0] prev;

    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_ready", ready8, 1);
    check_eq("rst_busy", busy8, 0);
    check_eq("rst_done", done8, 0);
    check_eq("rst_diff", diff8, 0);
    check_eq("rst_bout", bout8, 0);
    check_eq("rst4_diff_bout", {bout4, diff4}, 0);
`ifdef OVERFLOW_FLAG_EN
    check_eq("rst_ovf", ovf8, 0);
`endif

    // Directed vectors
    run8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run8("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run8("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8("t3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8("t3b", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start pulses during SHIFT are ignored
    start8 = 1'b1; a8 = 8'h40; b8 = 8'h11; bin8 = 1'b1;
    tick();
    start8 = 1'b0;
    check_eq("t4_busy", busy8, 1);
    dones = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 3 || i == 6) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (done8) begin
        dones++;
        check_eq("t4_diff", diff8, 8'h2E);
        check_eq("t4_bout", bout8, 0);
      end
    end
    start8 = 1'b0;
    check_eq("t4_one_done", dones, 1);

    // Start held through DONE -> immediate next op
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0;
    tick();
    a8 = 8'h09; b8 = 8'h04; bin8 = 1'b1;
    wait_done8(cyc);
    check_eq("t4b_lat1", cyc, 8);
    check_eq("t4b_diff1", diff8, 8'hF0);
    check_eq("t4b_bout1", bout8, 1);
    tick();
    start8 = 1'b0;
    check_eq("t4b_no_idle", busy8, 1);
    wait_done8(cyc);
    check_eq("t4b_lat2", cyc, 8);
    check_eq("t4b_diff2", diff8, 8'h04);
    check_eq("t4b_bout2", bout8, 0);
    tick();

    // Reset mid-SHIFT discards the partial result
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_ready", ready8, 1);
    check_eq("t5_busy", busy8, 0);
    check_eq("t5_done", done8, 0);
    check_eq("t5_diff", diff8, 0);
    check_eq("t5_bout", bout8, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) dones++;
    end
    check_eq("t5_no_done", dones, 0);

    // WIDTH=4 exhaustive
    bad = 0;
    prev = diff4;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0];
          tick();
          start4 = 1'b0;
          cyc = 0;
          while (!done4 && cyc < 20) begin
            if (diff4 !== prev) bad++;
            tick();
            cyc++;
          end
          e = (ai - bi - ci) & 31;
          if (cyc != 4) bad++;
          check_eq($sformatf("w4_%0d_%0d_%0d", ai, bi, ci), {bout4, diff4}, e);
          prev = diff4;
          tick();
          if (diff4 !== prev) bad++;
        end
      end
    end
    check_eq("w4_stable_latency", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
